// File: rtl/i2c_single_reg_ctrl.sv
// i2c_single_reg_ctrl
//   Local-side controller for the I2C single-register slave.
//   - Round-robin arbiter that loads the slave register from NUM_REQ on-chip
//     requesters via reg_data_in / reg_data_latch. After each load it forces
//     HOLDOFF idle cycles before it grants again.
//   - Change detector on the slave's data_out. Each value written by the I2C
//     host is reported through a single-entry valid/ready buffer. A sticky
//     overflow flag records any event that was lost.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_valid       [NUM_REQ]   per-requester load request
//   req_data        [8*NUM_REQ] per-requester byte (requester i at [8i+7:8i])
//   req_ready       [NUM_REQ]   one-hot grant (combinational, IDLE only)
//   reg_data_in     [8]         byte to slave data_in
//   reg_data_latch              registered load strobe to slave data_latch
//   reg_data_out    [8]         slave data_out
//   host_valid/host_data/host_ready  host-write event buffer
//   host_overflow               sticky lost-event flag
//   overflow_clr                clears host_overflow
//   busy                        arbiter not in IDLE
//
// Handshake: a requester transfer happens in a cycle where
// req_valid[i] && req_ready[i]. A host event is consumed in a cycle where
// host_valid && host_ready. Neither ready depends on the matching valid of
// the same interface, apart from the arbiter's grant selection.
module i2c_single_reg_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int HOLDOFF = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           reg_data_in,
  output logic                 reg_data_latch,
  input  logic [7:0]           reg_data_out,
  output logic                 host_valid,
  output logic [7:0]           host_data,
  input  logic                 host_ready,
  output logic                 host_overflow,
  input  logic                 overflow_clr,
  output logic                 busy
);

  localparam int PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW        = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
  localparam int HOLD_LOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic          any_req;
  logic [PW-1:0] winner;
  int unsigned   sel_idx;

  // Round-robin search from ptr upward with wrap. The loop runs from the
  // farthest offset down to offset 0, so the last match it records is the
  // one nearest the pointer.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    sel_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sel_idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[sel_idx]) begin
        any_req = 1'b1;
        winner  = PW'(sel_idx);
      end
    end
  end

  // Next-state and grant decode.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          req_ready[winner] = 1'b1;
          state_nx          = LATCH;
        end
      end
      LATCH:   state_nx = (HOLDOFF == 0) ? IDLE : HOLD;
      HOLD:    if (cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      cnt            <= '0;
      reg_data_in    <= '0;
      reg_data_latch <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        reg_data_in    <= req_data[{winner, 3'b000} +: 8];
        reg_data_latch <= 1'b1;
        ptr            <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
      end else begin
        reg_data_latch <= 1'b0;
      end
      if (state == LATCH) begin
        cnt <= CW'(HOLD_LOAD);
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign busy = (state != IDLE);

  // Change detection. latch_d lines up with the cycle in which our own load
  // appears on reg_data_out, so that load is not reported as a host write.
  // primed suppresses the first cycle after reset, when the shadow still
  // holds 0 and not the real register value.
  logic [7:0] shadow;
  logic       latch_d;
  logic       primed;
  logic       host_event;

  assign host_event = primed && (reg_data_out != shadow) && !latch_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow        <= '0;
      latch_d       <= 1'b0;
      primed        <= 1'b0;
      host_valid    <= 1'b0;
      host_data     <= '0;
      host_overflow <= 1'b0;
    end else begin
      shadow  <= reg_data_out;
      latch_d <= reg_data_latch;
      primed  <= 1'b1;
      if (host_event) begin
        // The newest value always wins. If an unconsumed event gets
        // overwritten, that loss is recorded.
        host_data  <= reg_data_out;
        host_valid <= 1'b1;
        if (host_valid && !host_ready) host_overflow <= 1'b1;
        else if (overflow_clr)         host_overflow <= 1'b0;
      end else begin
        if (host_valid && host_ready) host_valid    <= 1'b0;
        if (overflow_clr)             host_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_single_reg_ctrl.sv
// Directed testbench for i2c_single_reg_ctrl (NUM_REQ=4, HOLDOFF=2).
// Includes a behavioural model of the slave register: a latch takes priority
// over a host write in the same cycle.
module tb_i2c_single_reg_ctrl;

  localparam int NUM_REQ = 4;
  localparam int HOLDOFF = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           reg_data_in;
  logic                 reg_data_latch;
  logic [7:0]           reg_data_out;
  logic                 host_valid;
  logic [7:0]           host_data;
  logic                 host_ready   = 1'b0;
  logic                 host_overflow;
  logic                 overflow_clr = 1'b0;
  logic                 busy;

  // slave model
  logic [7:0] slave_reg = 8'h00;
  logic       host_wr   = 1'b0;
  logic [7:0] host_wval = 8'h00;

  always @(posedge clk) begin
    if (reg_data_latch) slave_reg <= reg_data_in;
    else if (host_wr)   slave_reg <= host_wval;
  end
  assign reg_data_out = slave_reg;

  i2c_single_reg_ctrl #(.NUM_REQ(NUM_REQ), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .reg_data_in(reg_data_in), .reg_data_latch(reg_data_latch),
    .reg_data_out(reg_data_out),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .host_overflow(host_overflow), .overflow_clr(overflow_clr),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // driver tasks: inputs change 1 time unit after the rising edge; checks
  // run 4 time units after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [NUM_REQ-1:0] exp_ready;

  initial begin
    // ---------------- reset state ----------------
    cyc(); cyc();
    settle();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_data_in", 32'(reg_data_in), 0);
    chk("rst_latch", 32'(reg_data_latch), 0);
    chk("rst_host_valid", 32'(host_valid), 0);
    chk("rst_host_data", 32'(host_data), 0);
    chk("rst_overflow", 32'(host_overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    cyc();
    rst = 1'b0;
    cyc(); cyc();

    // ---------------- host write 0x00 -> 0x3C ----------------
    host_wr = 1'b1; host_wval = 8'h3C;
    cyc();
    host_wr = 1'b0;
    settle();
    chk("hw_not_yet", 32'(host_valid), 0);
    cyc();
    settle();
    chk("hw_valid", 32'(host_valid), 1);
    chk("hw_data", 32'(host_data), 32'h3C);
    chk("hw_no_busy", 32'(busy), 0);
    host_ready = 1'b1;
    cyc();
    host_ready = 1'b0;
    settle();
    chk("hw_drained", 32'(host_valid), 0);
    chk("hw_no_ovf", 32'(host_overflow), 0);

    // ---------------- overflow ----------------
    host_wr = 1'b1; host_wval = 8'h11;
    cyc();
    host_wval = 8'h22;
    cyc();
    host_wr = 1'b0;
    settle();
    chk("ovf_first_data", 32'(host_data), 32'h11);
    chk("ovf_first_flag", 32'(host_overflow), 0);
    cyc();
    settle();
    chk("ovf_data", 32'(host_data), 32'h22);
    chk("ovf_flag", 32'(host_overflow), 1);
    chk("ovf_valid", 32'(host_valid), 1);
    overflow_clr = 1'b1;
    cyc();
    overflow_clr = 1'b0;
    settle();
    chk("ovf_cleared", 32'(host_overflow), 0);
    // clear and a new event in the same cycle: the set wins
    host_wr = 1'b1; host_wval = 8'h55;
    cyc();
    host_wr = 1'b0;
    overflow_clr = 1'b1;
    cyc();
    overflow_clr = 1'b0;
    settle();
    chk("ovf_set_wins", 32'(host_overflow), 1);
    chk("ovf_data55", 32'(host_data), 32'h55);
    host_ready = 1'b1; overflow_clr = 1'b1;
    cyc();
    host_ready = 1'b0; overflow_clr = 1'b0;
    settle();
    chk("ovf_drain_valid", 32'(host_valid), 0);
    chk("ovf_drain_flag", 32'(host_overflow), 0);

    // ---------------- collision: latch 0x77 vs host write 0x99 ----------------
    req_data[15:8] = 8'h77;
    req_valid = 4'b0010;
    settle();
    chk("col_grant", 32'(req_ready), 32'b0010);
    cyc();
    req_valid = 4'b0000;
    host_wr = 1'b1; host_wval = 8'h99;
    settle();
    chk("col_latch", 32'(reg_data_latch), 1);
    cyc();
    host_wr = 1'b0;
    settle();
    chk("col_reg_out", 32'(reg_data_out), 32'h77);
    cyc();
    settle();
    chk("col_no_event", 32'(host_valid), 0);
    cyc(); cyc();
    settle();
    chk("col_no_event2", 32'(host_valid), 0);
    chk("col_idle", 32'(busy), 0);

    // ---------------- single load: requester 2, 0xA5 ----------------
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    settle();
    chk("sl_ready", 32'(req_ready), 32'b0100);
    chk("sl_busy0", 32'(busy), 0);
    cyc();
    req_valid = 4'b0000;
    settle();
    chk("sl_latch", 32'(reg_data_latch), 1);
    chk("sl_data_in", 32'(reg_data_in), 32'hA5);
    chk("sl_busy1", 32'(busy), 1);
    chk("sl_ready_off", 32'(req_ready), 0);
    cyc();
    settle();
    chk("sl_latch_off", 32'(reg_data_latch), 0);
    chk("sl_busy2", 32'(busy), 1);
    cyc();
    settle();
    chk("sl_busy3", 32'(busy), 1);
    cyc();
    settle();
    chk("sl_busy_end", 32'(busy), 0);
    chk("sl_no_event", 32'(host_valid), 0);
    chk("sl_reg_out", 32'(reg_data_out), 32'hA5);

    // ---------------- round-robin from pointer 0 ----------------
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
    req_valid = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      settle();
      exp_ready = (i % 4 == 0) ? NUM_REQ'(1 << ((i / 4) % 4)) : '0;
      chk($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(exp_ready));
      if (i == 5) chk("rr_data1", 32'(reg_data_in), 32'h21);
      cyc();
    end
    req_valid = 4'b0000;
    settle();
    chk("rr_no_event", 32'(host_valid), 0);

    // ---------------- reset mid-LATCH ----------------
    // pointer is now 1; requester 0 alone must win by wrap-around
    req_data[7:0] = 8'h5A;
    req_valid = 4'b0001;
    settle();
    chk("rl_wrap_grant", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = 4'b0000;
    settle();
    chk("rl_latch_on", 32'(reg_data_latch), 1);
    rst = 1'b1;
    #1;
    chk("rl_latch_drop", 32'(reg_data_latch), 0);
    chk("rl_busy_drop", 32'(busy), 0);
    cyc();
    rst = 1'b0;
    settle();
    chk("rl_reg_kept", 32'(reg_data_out), 32'h10);
    cyc();
    settle();
    chk("rl_no_event1", 32'(host_valid), 0);
    cyc();
    settle();
    chk("rl_no_event2", 32'(host_valid), 0);
    req_valid = 4'b1111;
    settle();
    chk("rl_ptr0", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = 4'b0000;
    cyc(); cyc(); cyc();

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
